// File: rtl/qos_ingress_shaper_if.sv
// Handshake bundle between the ingress shaper, its upstream source and the
// downstream QoS arbiter port. The shaper uses the slave view; the
// environment (source plus arbiter) uses the master view.
interface qos_ingress_shaper_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PRIO_WIDTH = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [PRIO_WIDTH-1:0] in_prio;
  logic                  req_valid;
  logic [PRIO_WIDTH-1:0] req_prio;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  grant_ack;

  modport master (
    output in_valid, in_data, in_prio, grant_ack,
    input  in_ready, req_valid, req_prio, req_data
  );

  modport slave (
    input  in_valid, in_data, in_prio, grant_ack,
    output in_ready, req_valid, req_prio, req_data
  );
endinterface

// File: rtl/qos_ingress_shaper.sv
// Per-port ingress shaper: small flit FIFO, token-bucket rate limiter and
// head-of-line age escalation feeding one port of the NoC QoS arbiter.
module qos_ingress_shaper #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PRIO_WIDTH  = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TOKEN_WIDTH = 16,
  parameter int unsigned AGE_LIMIT   = 255,
  parameter int unsigned AGE_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  qos_ingress_shaper_if.slave     bus,
  input  logic [TOKEN_WIDTH-1:0]  cfg_rate,
  input  logic [TOKEN_WIDTH-1:0]  cfg_burst,
  input  logic [TOKEN_WIDTH-1:0]  cfg_cost,
  output logic [TOKEN_WIDTH-1:0]  token_level,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [1:0]              shaper_status
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_THROTTLED = 2'd1,
    ST_REQUEST   = 2'd2,
    ST_AGED      = 2'd3
  } status_e;

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [PRIO_WIDTH-1:0]  prio_mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [TOKEN_WIDTH-1:0] tokens;
  logic [TOKEN_WIDTH-1:0] tokens_next;
  logic [AGE_WIDTH-1:0]   age;
  logic [TOKEN_WIDTH:0]   t_spent;
  logic [TOKEN_WIDTH:0]   t_refill;
  logic                   empty;
  logic                   full;
  logic                   aged;
  logic                   can_pay;
  logic                   push;
  logic                   fire;
  status_e                status;

  // Handshake qualifiers, all derived from registered state plus the strobes.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    aged    = (age == AGE_WIDTH'(AGE_LIMIT));
    can_pay = (tokens >= cfg_cost);
    push    = bus.in_valid && !full;
    fire    = !empty && can_pay && bus.grant_ack;
  end

  // Bucket update at one extra bit: spend on fire, refill, clip to ceiling.
  always_comb begin
    t_spent     = {1'b0, tokens} - (fire ? {1'b0, cfg_cost} : '0);
    t_refill    = t_spent + {1'b0, cfg_rate};
    tokens_next = (t_refill > {1'b0, cfg_burst}) ? cfg_burst
                                                 : t_refill[TOKEN_WIDTH-1:0];
  end

  // Pointers, occupancy, token bucket and head age.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tokens <= '0;
      age    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push, fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      tokens <= tokens_next;
      if (empty || fire) age <= '0;
      else if (!aged)    age <= age + 1'b1;
    end
  end

  // Flit storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      prio_mem[wr_ptr] <= bus.in_prio;
    end
  end

  // Head status decode and output drive; head fields are masked while empty.
  always_comb begin
    status = ST_IDLE;
    if (empty)        status = ST_IDLE;
    else if (aged)    status = ST_AGED;
    else if (!can_pay) status = ST_THROTTLED;
    else              status = ST_REQUEST;

    bus.in_ready  = !full;
    bus.req_valid = !empty && can_pay;
    bus.req_prio  = empty ? '0 : (aged ? '1 : prio_mem[rd_ptr]);
    bus.req_data  = empty ? '0 : data_mem[rd_ptr];
    token_level   = tokens;
    fifo_count    = count;
    shaper_status = status;
  end

endmodule

// File: tb/tb_qos_ingress_shaper.sv
// Self-checking bench for qos_ingress_shaper: a table of single-flit vectors,
// hand-written multi-cycle sequences, and a negedge scoreboard/model that
// tracks FIFO order, token bucket and head age every cycle.
module tb_qos_ingress_shaper;

  localparam int unsigned LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_rate = '0;
  logic [15:0] cfg_burst = '0;
  logic [15:0] cfg_cost = '0;
  logic [15:0] token_level;
  logic [3:0]  fifo_count;
  logic [1:0]  shaper_status;

  qos_ingress_shaper_if #(.DATA_WIDTH(64), .PRIO_WIDTH(2)) bus ();

  qos_ingress_shaper #(
    .DATA_WIDTH(64), .PRIO_WIDTH(2), .DEPTH(8),
    .TOKEN_WIDTH(16), .AGE_LIMIT(LIM), .AGE_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_rate(cfg_rate), .cfg_burst(cfg_burst), .cfg_cost(cfg_cost),
    .token_level(token_level), .fifo_count(fifo_count),
    .shaper_status(shaper_status)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed { logic [63:0] data; logic [1:0] prio; } flit_t;
  flit_t       sb[$];
  int unsigned mtok = 0;
  int unsigned mage = 0;
  int unsigned mcnt;
  int unsigned t_m;
  int          n_push = 0;
  int          n_fire = 0;
  logic        m_valid, m_fire, m_push;
  logic [1:0]  m_status, m_prio;
  logic [63:0] m_data;

  // Compare every output against the model, then advance the model one edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mtok = 0;
      mage = 0;
    end else begin
      mcnt    = sb.size();
      m_valid = (mcnt != 0) && (mtok >= cfg_cost);
      if (mcnt == 0)          m_status = 2'd0;
      else if (mage == LIM)   m_status = 2'd3;
      else if (mtok < cfg_cost) m_status = 2'd1;
      else                    m_status = 2'd2;
      m_prio = (mcnt == 0) ? 2'd0 : ((mage == LIM) ? 2'd3 : sb[0].prio);
      m_data = (mcnt == 0) ? 64'd0 : sb[0].data;
      check("mon_fifo_count", fifo_count, mcnt);
      check("mon_token_level", token_level, mtok);
      check("mon_in_ready", bus.in_ready, mcnt != 8);
      check("mon_req_valid", bus.req_valid, m_valid);
      check("mon_status", shaper_status, m_status);
      check("mon_req_prio", bus.req_prio, m_prio);
      check("mon_req_data", bus.req_data, m_data);
      m_fire = m_valid && bus.grant_ack;
      m_push = bus.in_valid && (mcnt != 8);
      if (m_fire) begin void'(sb.pop_front()); n_fire++; end
      if (m_push) begin sb.push_back('{bus.in_data, bus.in_prio}); n_push++; end
      t_m  = mtok - (m_fire ? cfg_cost : 16'd0) + cfg_rate;
      mtok = (t_m > cfg_burst) ? cfg_burst : t_m;
      if (mcnt == 0 || m_fire) mage = 0;
      else if (mage < LIM)     mage = mage + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.grant_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] rate, burst, cost;
    logic [1:0]  prio;
    logic [63:0] data;
    int unsigned waits;
    logic        exp_valid;
    logic [1:0]  exp_status;
    logic [1:0]  exp_prio;
  } vec_t;

  vec_t vecs[8];
  int   fires, last_fire, p0, f0;
  logic tok_ok;

  initial begin
    vecs[0] = '{16'd64,  16'd256, 16'd64, 2'd1, 64'hA5,   0, 1'b1, 2'd2, 2'd1};
    vecs[1] = '{16'd16,  16'd256, 16'd64, 2'd2, 64'h11,   0, 1'b0, 2'd1, 2'd2};
    vecs[2] = '{16'd16,  16'd256, 16'd64, 2'd2, 64'h22,   3, 1'b1, 2'd2, 2'd2};
    vecs[3] = '{16'd16,  16'd256, 16'd64, 2'd0, 64'h33,   2, 1'b0, 2'd1, 2'd0};
    vecs[4] = '{16'd100, 16'd50,  16'd64, 2'd1, 64'h44,   2, 1'b0, 2'd1, 2'd1};
    vecs[5] = '{16'd10,  16'd256, 16'd64, 2'd1, 64'h55,   4, 1'b0, 2'd3, 2'd3};
    vecs[6] = '{16'd64,  16'd64,  16'd0,  2'd3, 64'h66,   0, 1'b1, 2'd2, 2'd3};
    vecs[7] = '{16'd1,   16'd256, 16'd3,  2'd0, 64'h77,   1, 1'b0, 2'd1, 2'd0};

    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_prio = '0;
    bus.grant_ack = 1'b0;
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_req_valid", bus.req_valid, 1'b0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_token_level", token_level, 0);
    check("reset_status", shaper_status, 0);
    do_reset();

    // Table-driven single-flit vectors, each from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cfg_rate = vecs[i].rate;
      cfg_burst = vecs[i].burst;
      cfg_cost = vecs[i].cost;
      bus.in_valid = 1'b1;
      bus.in_prio = vecs[i].prio;
      bus.in_data = vecs[i].data;
      step();
      bus.in_valid = 1'b0;
      for (int w = 0; w < int'(vecs[i].waits); w++) step();
      check($sformatf("vec%0d_req_valid", i), bus.req_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_status", i), shaper_status, vecs[i].exp_status);
      check($sformatf("vec%0d_req_prio", i), bus.req_prio, vecs[i].exp_prio);
      check($sformatf("vec%0d_req_data", i), bus.req_data, vecs[i].data);
      bus.grant_ack = 1'b1;
      step();
      bus.grant_ack = 1'b0;
      check($sformatf("vec%0d_count_after_grant", i), fifo_count, vecs[i].exp_valid ? 0 : 1);
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_status_after_grant", i), shaper_status, 0);
    end

    // Full and wrap: 9 offered, 8 accepted, then pop through the wrap.
    do_reset();
    cfg_rate = 16'd64; cfg_burst = 16'd256; cfg_cost = 16'd64;
    p0 = n_push; f0 = n_fire;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 64'h1000 + 64'(i);
      bus.in_prio = 2'(i);
      step();
    end
    check("full_count", fifo_count, 8);
    check("full_in_ready", bus.in_ready, 1'b0);
    check("full_accepted", n_push - p0, 8);
    bus.grant_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 64'h2000 + 64'(i);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (10) step();
    bus.grant_ack = 1'b0;
    check("wrap_pushes", n_push - p0, 15);
    check("wrap_fires", n_fire - f0, 15);
    check("wrap_empty", fifo_count, 0);

    // Rate limiting: one fire every 4 cycles, bucket never above 64.
    do_reset();
    cfg_rate = 16'd16; cfg_burst = 16'd64; cfg_cost = 16'd64;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 64'h3000 + 64'(i);
      step();
    end
    bus.in_valid = 1'b0;
    bus.grant_ack = 1'b1;
    fires = 0; last_fire = -1; tok_ok = 1'b1;
    for (int s = 0; s < 16; s++) begin
      if (token_level > 16'd64) tok_ok = 1'b0;
      if (bus.req_valid) begin
        if (last_fire >= 0) check("rate_gap", s - last_fire, 4);
        last_fire = s;
        fires++;
      end
      step();
    end
    bus.grant_ack = 1'b0;
    check("rate_fires", fires, 4);
    check("rate_token_cap", tok_ok, 1'b1);

    // Burst cap, then three consecutive fires and throttling.
    do_reset();
    cfg_rate = 16'd50; cfg_burst = 16'd200; cfg_cost = 16'd64;
    repeat (100) step();
    check("burst_level", token_level, 200);
    cfg_rate = 16'd0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 64'h4000 + 64'(i);
      step();
    end
    bus.in_valid = 1'b0;
    bus.grant_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("burst_fire%0d", i), bus.req_valid, 1'b1);
      step();
    end
    check("burst_throttled_valid", bus.req_valid, 1'b0);
    check("burst_throttled_status", shaper_status, 1);
    check("burst_tokens_left", token_level, 8);
    repeat (2) step();
    bus.grant_ack = 1'b0;
    check("spurious_throttled_tokens", token_level, 8);
    check("spurious_throttled_count", fifo_count, 1);

    // Aging: head prio 0 escalates after 4 wait edges; next head keeps its own.
    do_reset();
    cfg_rate = 16'd64; cfg_burst = 16'd256; cfg_cost = 16'd64;
    bus.in_valid = 1'b1; bus.in_prio = 2'd0; bus.in_data = 64'hA0;
    step();
    bus.in_prio = 2'd2; bus.in_data = 64'hB0;
    step();
    bus.in_valid = 1'b0;
    repeat (2) step();
    check("age_pre_status", shaper_status, 2);
    check("age_pre_prio", bus.req_prio, 0);
    step();
    check("age_status", shaper_status, 3);
    check("age_prio", bus.req_prio, 3);
    bus.grant_ack = 1'b1;
    step();
    bus.grant_ack = 1'b0;
    check("age_next_prio", bus.req_prio, 2);
    check("age_next_data", bus.req_data, 64'hB0);
    check("age_next_status", shaper_status, 2);

    // Spurious grant while empty leaves tokens accumulating normally.
    do_reset();
    cfg_rate = 16'd8; cfg_burst = 16'd100; cfg_cost = 16'd64;
    bus.grant_ack = 1'b1;
    repeat (3) step();
    bus.grant_ack = 1'b0;
    check("spurious_empty_tokens", token_level, 24);
    check("spurious_empty_count", fifo_count, 0);
    check("spurious_empty_status", shaper_status, 0);

    // Asynchronous reset with 5 flits queued.
    do_reset();
    cfg_rate = 16'd64; cfg_burst = 16'd256; cfg_cost = 16'd64;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 64'h5000 + 64'(i);
      step();
    end
    bus.in_valid = 1'b0;
    check("midrst_pre_count", fifo_count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", fifo_count, 0);
    check("midrst_in_ready", bus.in_ready, 1'b1);
    check("midrst_req_valid", bus.req_valid, 1'b0);
    check("midrst_req_prio", bus.req_prio, 0);
    check("midrst_req_data", bus.req_data, 0);
    check("midrst_tokens", token_level, 0);
    check("midrst_status", shaper_status, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 64'h6000;
    step();
    bus.in_valid = 1'b0;
    check("midrst_first_push", fifo_count, 1);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/qos_ingress_shaper.md
# qos_ingress_shaper

Per-port ingress stage that sits directly upstream of the NoC QoS arbiter: one instance per arbiter port. It buffers incoming flits in a small FIFO, gates them with a token-bucket rate limiter, and escalates priority for flits that wait too long. Its outputs drive one bit of the arbiter's `req_valid` and one slice of `req_prio`, and the arbiter's `grant_ack` bit pops the head flit.

## Interface
Parameters:
- `DATA_WIDTH`, 64, flit payload width.
- `PRIO_WIDTH`, 2, priority field width.
- `DEPTH`, 8, FIFO entries; must be a power of 2 and at least 2.
- `TOKEN_WIDTH`, 16, width of the token bucket and rate/burst/cost configuration.
- `AGE_LIMIT`, 255, number of head-wait cycles before priority escalation; must be at least 1.
- `AGE_WIDTH`, 8, age counter width; must satisfy AGE_LIMIT < 2**AGE_WIDTH.

Ports (clock and reset first):
- `clk`  in  1  the block's single clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  upstream flit valid.
- `in_ready`  out  1  FIFO can accept a flit.
- `in_data`  in  DATA_WIDTH  flit payload.
- `in_prio`  in  PRIO_WIDTH  flit priority.
- `cfg_rate`  in  TOKEN_WIDTH  tokens added per cycle.
- `cfg_burst`  in  TOKEN_WIDTH  bucket ceiling.
- `cfg_cost`  in  TOKEN_WIDTH  tokens consumed per granted flit.
- `req_valid`  out  1  request to arbiter.
- `req_prio`  out  PRIO_WIDTH  effective priority of the head flit.
- `req_data`  out  DATA_WIDTH  head flit payload.
- `grant_ack`  in  1  arbiter grant; pops the head flit.
- `token_level`  out  TOKEN_WIDTH  current bucket contents.
- `fifo_count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `shaper_status`  out  2  head state: 0 IDLE, 1 THROTTLED, 2 REQUEST, 3 AGED.

## Operation
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (fifo_count != DEPTH)` and does not depend on `grant_ack`. When full, a pop in the same cycle does not open the input.
- **Pop ("fire"):** `fire = req_valid && grant_ack`. A `grant_ack` while `req_valid=0` is ignored, with no state change.
- **Simultaneous push and pop:** allowed when not full; `fifo_count` is unchanged. Read and write pointers wrap modulo DEPTH.
- **Request:** `req_valid = (fifo_count != 0) && (token_level >= cfg_cost)`. It is driven from registered state only; there is no combinational path from `in_*` or `grant_ack`.
- **Token update**, each cycle, computed at TOKEN_WIDTH+1 bits:
  - `t1 = token_level - (fire ? cfg_cost : 0)`.
  - `token_level_next = min(t1 + cfg_rate, cfg_burst)`.
  - `t1` never underflows, because fire requires `token_level >= cfg_cost`.
  - If `cfg_burst < cfg_cost`, the port never requests. This is legal and is a configuration error, not a hang to detect.
- **Age counter:**
  - Clears to 0 on fire and while the FIFO is empty.
  - Otherwise increments by 1 each cycle the head is present, saturating at AGE_LIMIT.
  - Counts in both THROTTLED and REQUEST.
- **Effective priority:** `req_prio` equals the head flit's stored prio. When `age == AGE_LIMIT`, it is forced to all ones.
- **`shaper_status`** is decoded from registered state:
  - IDLE: empty.
  - AGED: non-empty and `age == AGE_LIMIT`.
  - THROTTLED: non-empty, not aged, and `token_level < cfg_cost`.
  - REQUEST: otherwise.
- **Status transitions:**
  - IDLE→THROTTLED/REQUEST on the first push.
  - THROTTLED→REQUEST when tokens reach cost.
  - REQUEST/THROTTLED→AGED at the limit.
  - Any state→IDLE on popping the last entry.
  - Any state→THROTTLED/REQUEST (age reset) on popping with entries remaining.
- Configuration inputs may change at any time and take effect on the next token update.

## Timing
- **Reset values:**
  - `in_ready=1`, `req_valid=0`, `req_prio=0`, `req_data=0`.
  - `token_level=0`, `fifo_count=0`, `shaper_status=0`.
  - Pointers and age are 0. FIFO storage contents are don't-care, but `req_data` is masked to 0 while empty.
- **Reset mid-operation:** all buffered flits are discarded and outputs return to their reset values asynchronously. The first push is accepted on the first clock edge after deassertion.
- **Latency:**
  - A flit pushed at edge N is visible on `req_data`/`req_prio` after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
  - `req_valid` rises in cycle N+1 if tokens suffice.
- **Pop:** on fire at edge M, the next entry is presented in cycle M+1. Back-to-back fires are sustainable at one flit per cycle when `cfg_rate >= cfg_cost`.
- **Token refill:** from empty with rate R, tokens reach cost C after ceil(C/R) edges.
- **Aging:** AGED is asserted in the cycle after the AGE_LIMIT-th wait edge.

## Test plan
- **Basic flow:** reset, then `cfg_rate=64`, `cfg_burst=256`, `cfg_cost=64`; push one flit with prio 1 and data 0xA5 → `req_valid=1` with `req_prio=1` and `req_data=0xA5` one cycle later; assert `grant_ack` → `fifo_count` returns to 0 and `shaper_status=0`.
- **Full and wrap:** hold `grant_ack=0` and push 9 flits → exactly 8 are accepted and `in_ready=0`; then pop 8 while pushing 8 more → data comes out in order across the pointer wrap, with no loss or duplication.
- **Rate limiting:** `cfg_rate=16`, `cfg_cost=64`, `cfg_burst=64`, FIFO holding 4 flits, `grant_ack` held at 1 → one fire every 4 cycles and `token_level` never exceeds 64.
- **Burst cap:** idle for 100 cycles with `cfg_rate=50` and `cfg_burst=200` → `token_level=200`; then 3 flits at cost 64 → 3 consecutive fires, then throttling.
- **Aging:** `AGE_LIMIT=4`, head prio 0, tokens sufficient, `grant_ack=0` → `req_prio=3` and `shaper_status=3` after 4 wait edges; fire → age resets and the next head shows its own prio.
- **Corner cases:** spurious `grant_ack` while empty or throttled → no change in state or tokens; assert `rst_n` low mid-burst with 5 flits queued → outputs take reset values immediately, with `fifo_count=0` and `in_ready=1`.
